// File: rtl/encoder.sv
// Registered MSB-first priority encoder: index of the highest set request bit plus valid.
// Optional macro ENCODER_MULTI_DET_EN adds a registered 'multi' flag (two or more bits set).
module encoder #(
    parameter  int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
`ifdef ENCODER_MULTI_DET_EN
    output logic             valid,
    output logic             multi
`else
    output logic             valid
`endif
);

    // any_above[i] is set when some bit strictly above i is set. It runs as a
    // chain from the MSB down.
    logic [WIDTH-1:0] any_above;
    logic [WIDTH-1:0] hit;
    logic [OUT_W-1:0] idx_next;
    logic             valid_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain
            if (gi == WIDTH - 1) begin : g_top
                assign any_above[gi] = 1'b0;
            end else begin : g_lower
                assign any_above[gi] = any_above[gi+1] | in[gi+1];
            end
            assign hit[gi] = in[gi] & ~any_above[gi];
        end
    endgenerate

    // hit is at most one-hot, so OR-ing the selected indices gives the encoded
    // value. An index code above WIDTH-1 can never be produced.
    always_comb begin
        idx_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (hit[i]) begin
                idx_next = idx_next | OUT_W'(i);
            end
        end
    end

    assign valid_next = any_above[0] | in[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= idx_next;
            valid <= valid_next;
        end
    end

`ifdef ENCODER_MULTI_DET_EN
    logic multi_next;

    // Any set bit other than the winning one means two or more requests are active.
    assign multi_next = |(in & ~hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi <= 1'b0;
        end else begin
            multi <= multi_next;
        end
    end
`endif

endmodule

// File: tb/tb_encoder.sv
// Directed bench for encoder: WIDTH=8 vector table, async reset behaviour, and a WIDTH=5 instance.
// Expected values are hand-computed. The multi checks are enabled when ENCODER_MULTI_DET_EN is defined.
module tb_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in8;
    logic [2:0] out8;
    logic       valid8;
    logic [4:0] in5;
    logic [2:0] out5;
    logic       valid5;
`ifdef ENCODER_MULTI_DET_EN
    logic       multi8;
    logic       multi5;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    encoder #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in8),
        .out   (out8),
`ifdef ENCODER_MULTI_DET_EN
        .valid (valid8),
        .multi (multi8)
`else
        .valid (valid8)
`endif
    );

    encoder #(.WIDTH(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in5),
        .out   (out5),
`ifdef ENCODER_MULTI_DET_EN
        .valid (valid5),
        .multi (multi5)
`else
        .valid (valid5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    // Vector table for WIDTH=8: input, expected index, valid, multi
    localparam int NV = 11;
    logic [7:0] v_in    [NV] = '{8'h08, 8'h80, 8'hAA, 8'h01, 8'h00, 8'h7F, 8'h03, 8'h10, 8'hFF, 8'h00, 8'h40};
    logic [2:0] v_out   [NV] = '{3'd3,  3'd7,  3'd7,  3'd0,  3'd0,  3'd6,  3'd1,  3'd4,  3'd7,  3'd0,  3'd6};
    logic       v_valid [NV] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    logic       v_multi [NV] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};

    // Vector table for WIDTH=5
    localparam int N5 = 4;
    logic [4:0] w_in    [N5] = '{5'b11111, 5'b00110, 5'b10000, 5'b00000};
    logic [2:0] w_out   [N5] = '{3'd4,     3'd2,     3'd4,     3'd0};
    logic       w_valid [N5] = '{1'b1,     1'b1,     1'b1,     1'b0};

    initial begin
        rst_n = 1'b0;
        in8   = 8'hFF;
        in5   = 5'b11111;
        #2;
        check("reset out", 32'(out8), 32'd0);
        check("reset valid", 32'(valid8), 32'd0);
`ifdef ENCODER_MULTI_DET_EN
        check("reset multi", 32'(multi8), 32'd0);
`endif
        // Clock edges while held in reset must not load anything.
        @(posedge clk); #1;
        check("held reset out", 32'(out8), 32'd0);
        check("held reset valid", 32'(valid8), 32'd0);
        rst_n = 1'b1;

        // Back-to-back vectors, one new input each cycle
        for (int k = 0; k < NV; k++) begin
            in8 = v_in[k];
            @(posedge clk); #1;
            check($sformatf("in=%02h out", v_in[k]), 32'(out8), 32'(v_out[k]));
            check($sformatf("in=%02h valid", v_in[k]), 32'(valid8), 32'(v_valid[k]));
`ifdef ENCODER_MULTI_DET_EN
            check($sformatf("in=%02h multi", v_in[k]), 32'(multi8), 32'(v_multi[k]));
`endif
        end

        // The last vector was 8'h40, so out=6 now. Pulse reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out", 32'(out8), 32'd0);
        check("async reset valid", 32'(valid8), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post reset out", 32'(out8), 32'd6);
        check("post reset valid", 32'(valid8), 32'd1);

        // Non-power-of-two width
        for (int k = 0; k < N5; k++) begin
            in5 = w_in[k];
            @(posedge clk); #1;
            check($sformatf("w5 in=%05b out", w_in[k]), 32'(out5), 32'(w_out[k]));
            check($sformatf("w5 in=%05b valid", w_in[k]), 32'(valid5), 32'(w_valid[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
